issue_sched: RTL and testbench

Parametrised issue scheduler and common-data-bus (CDB) arbiter for the Tomasulo back end. It supports NUM_FU execution units, each with a fixed, per-unit latency. Every cycle it grants issue requests so that no two results ever reach the single CDB in the same cycle, and it then muxes the finishing unit's result and tag onto the CDB. It replaces the fixed four-unit issue logic with a latency-indexed reservation shift register, round-robin fairness, unpipelined-unit back-pressure and flush.

---
 rtl/issue_sched_pkg.sv | 49 ++++
 rtl/issue_sched_rr_pick.sv | 32 +++
 rtl/issue_sched.sv | 157 +++++++++++++++
 tb/tb_issue_sched.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/issue_sched_pkg.sv
// issue_sched_pkg: shared unit indices, default latencies and latency-table helpers.
// Rev 1.0
`default_nettype none

package issue_sched_pkg;

    localparam int MAX_FU = 8;

    localparam int FU_INT  = 0;
    localparam int FU_LD   = 1;
    localparam int FU_MULT = 2;
    localparam int FU_DIV  = 3;

    localparam int DEF_NUM_FU  = 4;
    localparam int DEF_MAX_LAT = 8;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TAG_W   = 6;

    localparam logic [3:0] LAT_INT  = 4'd1;
    localparam logic [3:0] LAT_LD   = 4'd1;
    localparam logic [3:0] LAT_MULT = 4'd3;
    localparam logic [3:0] LAT_DIV  = 4'd6;

    localparam logic [4*DEF_NUM_FU-1:0] DEF_FU_LAT = {LAT_DIV, LAT_MULT, LAT_LD, LAT_INT};

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int lat_of(input logic [4*MAX_FU-1:0] lat_vec, input int idx);
        return int'(lat_vec[idx*4 +: 4]);
    endfunction

    // True when at least one of the first n units has the given latency.
    function automatic bit lat_used(input logic [4*MAX_FU-1:0] lat_vec, input int n,
                                    input int lat);
        bit used;
        used = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (int'(lat_vec[i*4 +: 4]) == lat) begin
                used = 1'b1;
            end
        end
        return used;
    endfunction

endpackage

`default_nettype wire

// File: rtl/issue_sched_rr_pick.sv
// rr_pick: N-way round-robin picker, first set request at or after ptr_i wins.
// Rev 1.0
`default_nettype none

module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr_i) + k) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/issue_sched.sv
// issue_sched: latency-indexed CDB reservation scheduler with per-latency round-robin issue.
// Rev 1.0
`default_nettype none

module issue_sched
    import issue_sched_pkg::*;
#(
    parameter int                 NUM_FU  = DEF_NUM_FU,
    parameter int                 MAX_LAT = DEF_MAX_LAT,
    parameter logic [4*NUM_FU-1:0] FU_LAT = DEF_FU_LAT,
    parameter int                 DATA_W  = DEF_DATA_W,
    parameter int                 TAG_W   = DEF_TAG_W
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic [NUM_FU-1:0]        req_i,
    input  logic [NUM_FU-1:0]        fu_busy_i,
    input  logic [NUM_FU*DATA_W-1:0] fu_result_i,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag_i,
    output logic [NUM_FU-1:0]        grant_o,
    output logic                     cdb_valid_o,
    output logic [DATA_W-1:0]        cdb_data_o,
    output logic [TAG_W-1:0]         cdb_tag_o,
    output logic [NUM_FU-1:0]        cdb_src_o
);

    localparam int                  FU_ID_W = id_width(NUM_FU);
    localparam logic [4*MAX_FU-1:0] LAT_VEC = (4*MAX_FU)'(FU_LAT);

    logic                              en_q;
    logic [MAX_LAT-1:0]                v_q, v_d;
    logic [MAX_LAT-1:0][FU_ID_W-1:0]   id_q, id_d;
    logic [FU_ID_W-1:0]                rr_ptr_q, rr_ptr_d;

    logic [NUM_FU-1:0]                 slot_free;
    logic [NUM_FU-1:0]                 elig;
    logic [MAX_LAT:1][NUM_FU-1:0]      cls_gnt;
    logic [NUM_FU-1:0]                 grant;
    logic                              ptr_found;
    logic [FU_ID_W-1:0]                ptr_idx;

    // A grant lands in r[L-1] after the shift, so it collides with whatever now sits in r[L].
    genvar gu, gl;
    generate
        for (gu = 0; gu < NUM_FU; gu++) begin : g_unit
            localparam int UL = lat_of(LAT_VEC, gu);
            if (UL >= MAX_LAT) begin : g_top_slot
                assign slot_free[gu] = 1'b1;
            end else begin : g_slot
                assign slot_free[gu] = ~v_q[UL];
            end
        end
    endgenerate

    // en_q keeps grants off while reset is held and until the first edge after release.
    assign elig = req_i & ~fu_busy_i & slot_free & {NUM_FU{en_q & ~flush_i}};

    generate
        for (gl = 1; gl <= MAX_LAT; gl++) begin : g_cls
            if (lat_used(LAT_VEC, NUM_FU, gl)) begin : g_pick
                logic [NUM_FU-1:0] cls_req;
                for (gu = 0; gu < NUM_FU; gu++) begin : g_mask
                    if (lat_of(LAT_VEC, gu) == gl) begin : g_in
                        assign cls_req[gu] = elig[gu];
                    end else begin : g_out
                        assign cls_req[gu] = 1'b0;
                    end
                end
                rr_pick #(
                    .N  (NUM_FU),
                    .PW (FU_ID_W)
                ) u_pick (
                    .req_i (cls_req),
                    .ptr_i (rr_ptr_q),
                    .gnt_o (cls_gnt[gl])
                );
            end else begin : g_none
                assign cls_gnt[gl] = '0;
            end
        end
    endgenerate

    always_comb begin
        grant = '0;
        for (int l = 1; l <= MAX_LAT; l++) begin
            grant = grant | cls_gnt[l];
        end
    end

    assign grant_o = grant;

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        ptr_found = 1'b0;
        ptr_idx   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            ptr_idx = FU_ID_W'((int'(rr_ptr_q) + k) % NUM_FU);
            if (!ptr_found && grant[ptr_idx]) begin
                rr_ptr_d  = FU_ID_W'((int'(ptr_idx) + 1) % NUM_FU);
                ptr_found = 1'b1;
            end
        end
    end

    always_comb begin
        v_d  = '0;
        id_d = '0;
        for (int k = 0; k < MAX_LAT - 1; k++) begin
            v_d[k]  = v_q[k+1];
            id_d[k] = id_q[k+1];
        end
        for (int i = 0; i < NUM_FU; i++) begin
            for (int k = 0; k < MAX_LAT; k++) begin
                if (grant[i] && (lat_of(LAT_VEC, i) == k + 1)) begin
                    v_d[k]  = 1'b1;
                    id_d[k] = FU_ID_W'(i);
                end
            end
        end
        if (flush_i) begin
            v_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q     <= 1'b0;
            v_q      <= '0;
            id_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            en_q     <= 1'b1;
            v_q      <= v_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign cdb_valid_o = v_q[0];

    always_comb begin
        cdb_data_o = '0;
        cdb_tag_o  = '0;
        cdb_src_o  = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (v_q[0] && (id_q[0] == FU_ID_W'(i))) begin
                cdb_data_o   = fu_result_i[i*DATA_W +: DATA_W];
                cdb_tag_o    = fu_tag_i[i*TAG_W +: TAG_W];
                cdb_src_o[i] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_issue_sched.sv
// tb_issue_sched: directed vectors with hand-computed grant and CDB expectations.
// Rev 1.0
`default_nettype none

module tb_issue_sched;
    import issue_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  busy = '0;
    logic [127:0] fu_result;
    logic [23:0] fu_tag;
    logic [3:0]  grant;
    logic        cdb_valid;
    logic [31:0] cdb_data;
    logic [5:0]  cdb_tag;
    logic [3:0]  cdb_src;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign fu_result = {32'hD00D_0003, 32'hD00D_0002, 32'hD00D_0001, 32'hD00D_0000};
    assign fu_tag    = {6'h13, 6'h12, 6'h11, 6'h10};

    issue_sched dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .req_i       (req),
        .fu_busy_i   (busy),
        .fu_result_i (fu_result),
        .fu_tag_i    (fu_tag),
        .grant_o     (grant),
        .cdb_valid_o (cdb_valid),
        .cdb_data_o  (cdb_data),
        .cdb_tag_o   (cdb_tag),
        .cdb_src_o   (cdb_src)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive after the falling edge, check before the next rising edge.
    task automatic apply(input string tag, input logic [3:0] r, input logic [3:0] b,
                         input logic f, input logic [3:0] eg, input logic ev,
                         input logic [3:0] es);
        logic [5:0]  etag;
        logic [31:0] edata;
        @(negedge clk);
        req = r; busy = b; flush = f;
        #1;
        etag  = '0;
        edata = '0;
        for (int u = 0; u < 4; u++) begin
            if (ev && es[u]) begin
                etag  = 6'(6'h10 + u);
                edata = 32'hD00D_0000 + 32'(u);
            end
        end
        check_val($sformatf("%s.grant", tag), 64'(grant), 64'(eg));
        check_val($sformatf("%s.valid", tag), 64'(cdb_valid), 64'(ev));
        check_val($sformatf("%s.src", tag), 64'(cdb_src), 64'(es));
        check_val($sformatf("%s.tag", tag), 64'(cdb_tag), 64'(etag));
        check_val($sformatf("%s.data", tag), 64'(cdb_data), 64'(edata));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0; flush = 1'b0; busy = '0; req = 4'($urandom);
        #1;
        check_val($sformatf("%s.rst_grant0", tag), 64'(grant), 64'd0);
        check_val($sformatf("%s.rst_valid0", tag), 64'(cdb_valid), 64'd0);
        @(negedge clk);
        req = 4'($urandom) | 4'b0001;
        #1;
        check_val($sformatf("%s.rst_grant1", tag), 64'(grant), 64'd0);
        check_val($sformatf("%s.rst_data", tag), 64'(cdb_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and first single-cycle issue.
        do_reset("s1");
        apply("s1.t0", 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000);
        apply("s1.t1", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0001);
        apply("s1.t2", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);

        // Two latency-1 units share one slot: round-robin alternation.
        do_reset("s2");
        apply("s2.t0", 4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000);
        apply("s2.t1", 4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b1, 4'b0001);
        apply("s2.t2", 4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0010);
        apply("s2.t3", 4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b1, 4'b0001);
        apply("s2.t4", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0010);
        apply("s2.t5", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);

        // Mult at t0 owns the t3 slot, so int is pushed from t2 to t3.
        do_reset("s3");
        apply("s3.t0", 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0, 4'b0000);
        apply("s3.t1", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);
        apply("s3.t2", 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);
        apply("s3.t3", 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0100);
        apply("s3.t4", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0001);
        apply("s3.t5", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);

        // Divider issue, busy back-pressure, mult/int steering around the div slot.
        do_reset("s4");
        apply("s4.t0", 4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b0, 4'b0000);
        apply("s4.t1", 4'b1100, 4'b1000, 1'b0, 4'b0100, 1'b0, 4'b0000);
        apply("s4.t2", 4'b1100, 4'b1000, 1'b0, 4'b0100, 1'b0, 4'b0000);
        apply("s4.t3", 4'b1101, 4'b1000, 1'b0, 4'b0000, 1'b0, 4'b0000);
        apply("s4.t4", 4'b1101, 4'b1000, 1'b0, 4'b0100, 1'b1, 4'b0100);
        apply("s4.t5", 4'b1101, 4'b1000, 1'b0, 4'b0100, 1'b1, 4'b0100);
        apply("s4.t6", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b1000);
        apply("s4.t7", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0100);
        apply("s4.t8", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0100);
        apply("s4.t9", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);

        // Flush: in-flight r[0] still broadcasts, mult is dropped, no grant.
        do_reset("s5");
        apply("s5.t0", 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0, 4'b0000);
        apply("s5.t1", 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000);
        apply("s5.t2", 4'b0101, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b0001);
        apply("s5.t3", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);
        apply("s5.t4", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);

        // Asynchronous reset with a div and an int in flight.
        do_reset("s6");
        apply("s6.t0", 4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b0, 4'b0000);
        apply("s6.t1", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);
        apply("s6.t2", 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000);
        apply("s6.t3", 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 4'b0001);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("s6.async_valid", 64'(cdb_valid), 64'd0);
        check_val("s6.async_grant", 64'(grant), 64'd0);
        check_val("s6.async_src", 64'(cdb_src), 64'd0);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 7; c++) begin
            apply($sformatf("s6.post%0d", c), 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
